// File: rtl/student_copy_pkg.sv
// student_copy_pkg: state encoding and bus
// constants for the TL-UL copy engine.
package student_copy_pkg;
  typedef enum logic [2:0] {
    CopyIdle,
    CopyRdA,
    CopyRdD,
    CopyWrA,
    CopyWrD
  } copy_state_e;

  localparam logic [1:0]  CopyASize = 2'd2;
  localparam logic [3:0]  CopyMask  = 4'hF;
  localparam logic [31:0] WordBytes = 32'd4;
endpackage

// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL channel types and opcodes
// shared by hosts and devices on the student bus.
package tlul_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;
  localparam int TL_DBW = TL_DW / 8;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef logic [7:0] tl_a_user_t;
  localparam tl_a_user_t TL_A_USER_DEFAULT = '0;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    tl_a_user_t        a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

// File: rtl/student_tlul_copy.sv
// student_tlul_copy: single-outstanding TL-UL host
// that copies len words from src to dst.
module student_tlul_copy
  import tlul_pkg::*;
  import student_copy_pkg::*;
#(
  parameter logic [TL_AIW-1:0] SourceId = '0,
  parameter int unsigned LenWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [31:0]         src_addr_i,
  input  logic [31:0]         dst_addr_i,
  input  logic [LenWidth-1:0] len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output tl_h2d_t             tl_host_o,
  input  tl_d2h_t             tl_host_i
);

  copy_state_e state_q, state_d;

  logic [31:0]         src_q;
  logic [31:0]         dst_q;
  logic [31:0]         data_q;
  logic [LenWidth-1:0] len_q;
  logic [LenWidth-1:0] cnt_q;
  logic                done_q;
  logic                err_q;

  logic a_hs;
  logic d_hs;
  logic last;
  logic unused_in;

  assign a_hs = tl_host_o.a_valid & tl_host_i.a_ready;
  assign d_hs = tl_host_o.d_ready & tl_host_i.d_valid;
  assign last = (cnt_q + LenWidth'(1)) == len_q;

  assign busy_o = state_q != CopyIdle;
  assign done_o = done_q;
  assign err_o  = err_q;

  assign unused_in = ^{src_addr_i[1:0],
                       dst_addr_i[1:0],
                       tl_host_i.d_opcode,
                       tl_host_i.d_param,
                       tl_host_i.d_size,
                       tl_host_i.d_source,
                       tl_host_i.d_sink};

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CopyIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: abort on any d_error
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CopyIdle: begin
        if (start_i && len_i != '0) begin
          state_d = CopyRdA;
        end
      end
      CopyRdA: begin
        if (a_hs) state_d = CopyRdD;
      end
      CopyRdD: begin
        if (d_hs) begin
          state_d = tl_host_i.d_error ?
                    CopyIdle : CopyWrA;
        end
      end
      CopyWrA: begin
        if (a_hs) state_d = CopyWrD;
      end
      CopyWrD: begin
        if (d_hs) begin
          state_d = (tl_host_i.d_error || last) ?
                    CopyIdle : CopyRdA;
        end
      end
      default: state_d = CopyIdle;
    endcase
  end

  // pointers, count, data word and status flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q  <= '0;
      dst_q  <= '0;
      data_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        CopyIdle: begin
          if (start_i) begin
            src_q  <= {src_addr_i[31:2], 2'b00};
            dst_q  <= {dst_addr_i[31:2], 2'b00};
            len_q  <= len_i;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            done_q <= len_i == '0;
          end
        end
        CopyRdD: begin
          if (d_hs) begin
            data_q <= tl_host_i.d_data;
            if (tl_host_i.d_error) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end
          end
        end
        CopyWrD: begin
          if (d_hs) begin
            if (tl_host_i.d_error) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              src_q  <= src_q + WordBytes;
              dst_q  <= dst_q + WordBytes;
              cnt_q  <= cnt_q + LenWidth'(1);
              done_q <= last;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // bus outputs decoded from the current state
  always_comb begin
    tl_host_o          = '0;
    tl_host_o.a_opcode = Get;
    tl_host_o.a_size   = CopyASize;
    tl_host_o.a_mask   = CopyMask;
    tl_host_o.a_source = SourceId;
    tl_host_o.a_user   = TL_A_USER_DEFAULT;
    unique case (state_q)
      CopyRdA: begin
        tl_host_o.a_valid   = 1'b1;
        tl_host_o.a_opcode  = Get;
        tl_host_o.a_address = src_q;
      end
      CopyWrA: begin
        tl_host_o.a_valid   = 1'b1;
        tl_host_o.a_opcode  = PutFullData;
        tl_host_o.a_address = dst_q;
        tl_host_o.a_data    = data_q;
      end
      CopyRdD, CopyWrD: begin
        tl_host_o.d_ready = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
